// File: rtl/fa_dma_pkg.sv
// Shared definitions for the DMA-to-MCB port arbiter: MCB command codes,
// FSM encoding and requester indices.
package fa_dma_pkg;

  localparam logic [2:0] MCB_INSTR_WR = 3'b000;
  localparam logic [2:0] MCB_INSTR_RD = 3'b001;

  localparam int REQ_CMD = 0;
  localparam int REQ_WGT = 1;
  localparam int REQ_DAT = 2;
  localparam int REQ_WB  = 3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_WDATA = 3'd2,
    ST_CMD   = 3'd3,
    ST_RDATA = 3'd4,
    ST_DONE  = 3'd5
  } arb_state_t;

endpackage

// File: rtl/dma_port_arbiter_rr_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr,
// wrapping modulo N. Returns a one-hot pick and an any-request flag.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic          any
);

  always_comb begin
    pick = '0;
    any  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        pick[(int'(ptr) + k) % N] = 1'b1;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_port_arbiter.sv
// Round-robin arbiter sharing one MCB user port between NREQ DMA requesters,
// one burst in flight; write data is pushed before the write command.
module dma_port_arbiter
  import fa_dma_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int BL_W   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*BL_W-1:0]     req_bl,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          wdata_pull,
  output logic [DATA_W-1:0]        rdata,
  output logic [NREQ-1:0]          rdata_valid,
  output logic [NREQ-1:0]          done,
  output logic                     mcb_cmd_en,
  output logic [2:0]               mcb_cmd_instr,
  output logic [BL_W-1:0]          mcb_cmd_bl,
  output logic [ADDR_W-1:0]        mcb_cmd_addr,
  input  logic                     mcb_cmd_full,
  output logic                     mcb_wr_en,
  output logic [DATA_W-1:0]        mcb_wr_data,
  input  logic                     mcb_wr_full,
  output logic                     mcb_rd_en,
  input  logic [DATA_W-1:0]        mcb_rd_data,
  input  logic                     mcb_rd_empty,
  output logic                     busy,
  output arb_state_t               state_dbg
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t      state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   pick_idx;
  logic [PW-1:0]   ptr_next;
  logic [NREQ-1:0] pick;
  logic            pick_any;
  logic            lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [BL_W-1:0] lat_bl;
  // One bit wider than bl so a full 2^BL_W-beat burst never wraps.
  logic [BL_W:0]   beat_cnt;
  logic            last_beat;
  logic            wr_go;
  logic            rd_go;
  logic            in_cmd;

  rr_pick #(.N(NREQ), .PW(PW)) u_pick (
    .req  (req),
    .ptr  (ptr),
    .pick (pick),
    .any  (pick_any)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick[i]) pick_idx = PW'(i);
    end
  end

  assign ptr_next  = (pick_idx == PW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
  assign last_beat = (beat_cnt == {1'b0, lat_bl});
  assign wr_go     = (state == ST_WDATA) && !mcb_wr_full;
  assign rd_go     = (state == ST_RDATA) && !mcb_rd_empty;
  assign in_cmd    = (state == ST_CMD);

  assign mcb_wr_en     = wr_go;
  assign mcb_wr_data   = (state == ST_WDATA) ? req_wdata[owner*DATA_W +: DATA_W] : '0;
  assign wdata_pull    = wr_go ? gnt : '0;
  assign mcb_cmd_en    = in_cmd && !mcb_cmd_full;
  assign mcb_cmd_instr = in_cmd ? (lat_we ? MCB_INSTR_WR : MCB_INSTR_RD) : 3'b000;
  assign mcb_cmd_bl    = in_cmd ? lat_bl : '0;
  assign mcb_cmd_addr  = in_cmd ? lat_addr : '0;
  assign mcb_rd_en     = rd_go;
  assign rdata         = rd_go ? mcb_rd_data : '0;
  assign rdata_valid   = rd_go ? gnt : '0;
  assign done          = (state == ST_DONE) ? gnt : '0;
  assign busy          = (state != ST_IDLE);
  assign state_dbg     = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      ptr      <= '0;
      owner    <= '0;
      gnt      <= '0;
      lat_we   <= 1'b0;
      lat_addr <= '0;
      lat_bl   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: if (|req) state <= ST_ARB;
        ST_ARB: begin
          // A request may have been withdrawn during IDLE; then just go back.
          if (pick_any) begin
            owner    <= pick_idx;
            gnt      <= pick;
            lat_we   <= req_we[pick_idx];
            lat_addr <= req_addr[pick_idx*ADDR_W +: ADDR_W];
            lat_bl   <= req_bl[pick_idx*BL_W +: BL_W];
            ptr      <= ptr_next;
            state    <= req_we[pick_idx] ? ST_WDATA : ST_CMD;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_WDATA: if (wr_go) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) state <= ST_CMD;
        end
        ST_CMD: if (!mcb_cmd_full) state <= lat_we ? ST_DONE : ST_RDATA;
        ST_RDATA: if (rd_go) begin
          beat_cnt <= beat_cnt + 1'b1;
          if (last_beat) state <= ST_DONE;
        end
        ST_DONE: begin
          gnt      <= '0;
          beat_cnt <= '0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_port_arbiter.sv
// Directed bench for dma_port_arbiter: read, write with back-pressure,
// round-robin order, command stall, maximum burst and mid-burst reset.
module tb_dma_port_arbiter;
  import fa_dma_pkg::*;

  logic          clk;
  logic          rst;
  logic [3:0]    req;
  logic [3:0]    req_we;
  logic [119:0]  req_addr;
  logic [23:0]   req_bl;
  logic [127:0]  req_wdata;
  logic [3:0]    gnt;
  logic [3:0]    wdata_pull;
  logic [31:0]   rdata;
  logic [3:0]    rdata_valid;
  logic [3:0]    done;
  logic          mcb_cmd_en;
  logic [2:0]    mcb_cmd_instr;
  logic [5:0]    mcb_cmd_bl;
  logic [29:0]   mcb_cmd_addr;
  logic          mcb_cmd_full;
  logic          mcb_wr_en;
  logic [31:0]   mcb_wr_data;
  logic          mcb_wr_full;
  logic          mcb_rd_en;
  logic [31:0]   mcb_rd_data;
  logic          mcb_rd_empty;
  logic          busy;
  arb_state_t    state_dbg;

  dma_port_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_bl(req_bl), .req_wdata(req_wdata), .gnt(gnt), .wdata_pull(wdata_pull),
    .rdata(rdata), .rdata_valid(rdata_valid), .done(done),
    .mcb_cmd_en(mcb_cmd_en), .mcb_cmd_instr(mcb_cmd_instr), .mcb_cmd_bl(mcb_cmd_bl),
    .mcb_cmd_addr(mcb_cmd_addr), .mcb_cmd_full(mcb_cmd_full),
    .mcb_wr_en(mcb_wr_en), .mcb_wr_data(mcb_wr_data), .mcb_wr_full(mcb_wr_full),
    .mcb_rd_en(mcb_rd_en), .mcb_rd_data(mcb_rd_data), .mcb_rd_empty(mcb_rd_empty),
    .busy(busy), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // MCB read FIFO model: bench pushes, DUT pops.
  logic [31:0] rd_mem [0:127];
  logic [7:0]  rd_wp = 8'd0;
  logic [7:0]  rd_rp = 8'd0;
  assign mcb_rd_empty = (rd_rp == rd_wp);
  assign mcb_rd_data  = rd_mem[rd_rp[6:0]];
  always @(posedge clk) if (mcb_rd_en) rd_rp <= rd_rp + 8'd1;

  // Requester 3 write-data source: next word on every pull.
  int          wptr3;
  logic [31:0] wd3;
  assign wd3       = 32'hC0DE_0000 + 32'(wptr3) * 32'h111;
  assign req_wdata = {wd3, 96'h0};

  // monitor
  logic        clr;
  int          n_wr_en, n_cmd, n_done, cmd_wr_snap;
  int          pull_cnt [4];
  int          rdv_cnt  [4];
  int          done_cnt [4];
  logic [3:0]  gnt_prev;
  logic [31:0] wr_log [$];
  logic [31:0] rd_log [$];
  logic [3:0]  gnt_log [$];

  always @(posedge clk) begin
    if (clr) begin
      n_wr_en = 0; n_cmd = 0; n_done = 0; cmd_wr_snap = 0;
      for (int i = 0; i < 4; i++) begin
        pull_cnt[i] = 0; rdv_cnt[i] = 0; done_cnt[i] = 0;
      end
      wr_log.delete(); rd_log.delete(); gnt_log.delete();
      gnt_prev = gnt;
      wptr3 <= 0;
    end else begin
      if (mcb_wr_en) begin n_wr_en++; wr_log.push_back(mcb_wr_data); end
      if (mcb_cmd_en) begin n_cmd++; cmd_wr_snap = n_wr_en; end
      if (|rdata_valid) rd_log.push_back(rdata);
      for (int i = 0; i < 4; i++) begin
        if (wdata_pull[i]) pull_cnt[i]++;
        if (rdata_valid[i]) rdv_cnt[i]++;
        if (done[i]) begin done_cnt[i]++; n_done++; end
      end
      if (gnt != 4'b0 && gnt_prev == 4'b0) gnt_log.push_back(gnt);
      gnt_prev = gnt;
      if (wdata_pull[3]) wptr3 <= wptr3 + 1;
    end
  end

  // scoreboard
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [29:0] addr, input logic [5:0] bl);
    req_we[i] = we;
    req_addr[i*30 +: 30] = addr;
    req_bl[i*6 +: 6] = bl;
  endtask

  task automatic load_rd(input int n, input logic [31:0] base);
    for (int k = 0; k < n; k++) begin
      rd_mem[rd_wp[6:0]] = base + 32'(k);
      exp_q.push_back(base + 32'(k));
      rd_wp = rd_wp + 8'd1;
    end
  endtask

  task automatic wait_done(input int idx, input int budget);
    int k;
    k = 0;
    while (done[idx] !== 1'b1 && k < budget) begin
      tick();
      k++;
    end
    chk($sformatf("done%0d_seen", idx), 64'(done[idx]), 64'd1);
  endtask

  task automatic cmp_queue(input string tag, input logic [31:0] got [$]);
    chk({tag, "_count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) chk(tag, 64'(got[k]), 64'(exp_q[k]));
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; req = '0; req_we = '0; req_addr = '0; req_bl = '0;
    mcb_cmd_full = 1'b0; mcb_wr_full = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_cmd_en", 64'(mcb_cmd_en), 64'd0);
    chk("rst_wr_en", 64'(mcb_wr_en), 64'd0);
    chk("rst_rd_en", 64'(mcb_rd_en), 64'd0);
    chk("rst_state", 64'(state_dbg), 64'(ST_IDLE));
    rst = 1'b0;

    // 1: single read, requester 2, bl=3
    clear_mon();
    set_req(REQ_DAT, 1'b0, 30'h000A_0000, 6'd3);
    load_rd(4, 32'h1111_0000);
    req = 4'b0100;
    tick();
    chk("t1_arb_state", 64'(state_dbg), 64'(ST_ARB));
    chk("t1_arb_gnt", 64'(gnt), 64'd0);
    tick();
    chk("t1_gnt", 64'(gnt), 64'b0100);
    chk("t1_cmd_en", 64'(mcb_cmd_en), 64'd1);
    chk("t1_cmd_instr", 64'(mcb_cmd_instr), 64'(MCB_INSTR_RD));
    chk("t1_cmd_bl", 64'(mcb_cmd_bl), 64'd3);
    chk("t1_cmd_addr", 64'(mcb_cmd_addr), 64'h000A_0000);
    wait_done(2, 20);
    chk("t1_done_gnt", 64'(gnt), 64'b0100);
    req = 4'b0000;
    tick();
    chk("t1_gnt_low", 64'(gnt), 64'd0);
    chk("t1_busy_low", 64'(busy), 64'd0);
    chk("t1_rdv2", 64'(rdv_cnt[2]), 64'd4);
    chk("t1_rdv_other", 64'(rdv_cnt[0] + rdv_cnt[1] + rdv_cnt[3]), 64'd0);
    chk("t1_done_cnt", 64'(done_cnt[2]), 64'd1);
    chk("t1_cmd_cnt", 64'(n_cmd), 64'd1);
    chk("t1_gnt_bursts", 64'(gnt_log.size()), 64'd1);
    chk("t1_gnt_onehot", 64'(gnt_log[0]), 64'b0100);
    cmp_queue("t1_rdata", rd_log);

    // 2: write, requester 3, bl=7, write FIFO full during beats 3-4
    clear_mon();
    set_req(REQ_WB, 1'b1, 30'h0000_3000, 6'd7);
    req = 4'b1000;
    tick();
    tick();
    chk("t2_gnt", 64'(gnt), 64'b1000);
    chk("t2_wr_en0", 64'(mcb_wr_en), 64'd1);
    chk("t2_wr_data0", 64'(mcb_wr_data), 64'hC0DE_0000);
    tick();
    tick();
    mcb_wr_full = 1'b1;
    #1;
    chk("t2_full_wr_en", 64'(mcb_wr_en), 64'd0);
    chk("t2_full_pull", 64'(wdata_pull), 64'd0);
    tick();
    tick();
    chk("t2_full_state", 64'(state_dbg), 64'(ST_WDATA));
    chk("t2_full_pushes", 64'(n_wr_en), 64'd2);
    mcb_wr_full = 1'b0;
    for (int k = 0; k < 30 && mcb_cmd_en !== 1'b1; k++) tick();
    chk("t2_cmd_seen", 64'(mcb_cmd_en), 64'd1);
    chk("t2_pushes_before_cmd", 64'(n_wr_en), 64'd8);
    chk("t2_cmd_instr", 64'(mcb_cmd_instr), 64'(MCB_INSTR_WR));
    chk("t2_cmd_bl", 64'(mcb_cmd_bl), 64'd7);
    chk("t2_cmd_addr", 64'(mcb_cmd_addr), 64'h0000_3000);
    wait_done(3, 10);
    req = 4'b0000;
    tick();
    chk("t2_wr_en_cnt", 64'(n_wr_en), 64'd8);
    chk("t2_pull_cnt", 64'(pull_cnt[3]), 64'd8);
    chk("t2_cmd_cnt", 64'(n_cmd), 64'd1);
    chk("t2_cmd_after", 64'(cmd_wr_snap), 64'd8);
    chk("t2_done_cnt", 64'(done_cnt[3]), 64'd1);
    for (int k = 0; k < 8; k++) exp_q.push_back(32'hC0DE_0000 + 32'(k) * 32'h111);
    cmp_queue("t2_wdata", wr_log);

    // 3: all four requesting, bl=0 reads, 8 bursts
    clear_mon();
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 30'(32'h100 * (i + 1)), 6'd0);
    load_rd(8, 32'h3333_0000);
    req = 4'b1111;
    for (int k = 0; k < 200 && n_done < 8; k++) tick();
    req = 4'b0000;
    tick();
    chk("t3_bursts", 64'(gnt_log.size()), 64'd8);
    for (int k = 0; k < 8; k++) begin
      logic [3:0] one;
      one = 4'b0001 << (k % 4);
      chk($sformatf("t3_gnt%0d", k), 64'(gnt_log[k]), 64'(one));
      if (k > 0) chk($sformatf("t3_repeat%0d", k), 64'(gnt_log[k] == gnt_log[k-1]), 64'd0);
    end
    for (int i = 0; i < 4; i++) chk($sformatf("t3_rdv%0d", i), 64'(rdv_cnt[i]), 64'd2);
    cmp_queue("t3_rdata", rd_log);

    // 4: command FIFO full for 5 cycles in CMD
    clear_mon();
    set_req(REQ_WGT, 1'b0, 30'h0000_0400, 6'd1);
    load_rd(2, 32'h4444_0000);
    mcb_cmd_full = 1'b1;
    req = 4'b0010;
    tick();
    tick();
    chk("t4_stall_state", 64'(state_dbg), 64'(ST_CMD));
    chk("t4_stall_cmd_en", 64'(mcb_cmd_en), 64'd0);
    repeat (4) tick();
    chk("t4_stall_cmd_cnt", 64'(n_cmd), 64'd0);
    mcb_cmd_full = 1'b0;
    #1;
    chk("t4_cmd_on_clear", 64'(mcb_cmd_en), 64'd1);
    chk("t4_cmd_addr", 64'(mcb_cmd_addr), 64'h0000_0400);
    wait_done(1, 10);
    req = 4'b0000;
    tick();
    chk("t4_cmd_cnt", 64'(n_cmd), 64'd1);
    cmp_queue("t4_rdata", rd_log);

    // 5: maximum burst, bl=63 read on requester 0
    clear_mon();
    set_req(REQ_CMD, 1'b0, 30'h0001_0000, 6'd63);
    load_rd(64, 32'h5555_0000);
    req = 4'b0001;
    wait_done(0, 100);
    chk("t5_rdv_at_done", 64'(rdv_cnt[0]), 64'd64);
    req = 4'b0000;
    tick();
    chk("t5_done_cnt", 64'(done_cnt[0]), 64'd1);
    chk("t5_busy_low", 64'(busy), 64'd0);
    chk("t5_fifo_drained", 64'(mcb_rd_empty), 64'd1);
    cmp_queue("t5_rdata", rd_log);

    // 6: reset in RDATA after 2 of 4 beats, then arbitration restarts at ptr 0
    clear_mon();
    set_req(REQ_DAT, 1'b0, 30'h0002_0000, 6'd3);
    load_rd(2, 32'h6666_0000);
    exp_q.delete();
    req = 4'b0100;
    for (int k = 0; k < 20 && rdv_cnt[2] < 2; k++) tick();
    chk("t6_two_pops", 64'(rdv_cnt[2]), 64'd2);
    chk("t6_stuck_rdata", 64'(state_dbg), 64'(ST_RDATA));
    rst = 1'b1;
    req = 4'b0000;
    tick();
    chk("t6_rst_gnt", 64'(gnt), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_rd_en", 64'(mcb_rd_en), 64'd0);
    rst = 1'b0;
    tick();
    chk("t6_no_done", 64'(done_cnt[2]), 64'd0);
    set_req(REQ_WGT, 1'b0, 30'h0000_0800, 6'd0);
    set_req(REQ_WB, 1'b0, 30'h0000_0C00, 6'd0);
    load_rd(1, 32'h7777_0000);
    exp_q.delete();
    req = 4'b1010;
    tick();
    tick();
    chk("t6_ptr0_gnt", 64'(gnt), 64'b0010);
    wait_done(1, 10);
    req = 4'b0000;
    tick();
    chk("t6_final_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
